// File: rtl/cgra_cfg_pkg.sv
// Shared constants and types for the CGRA tile configuration responder.
// Opcodes, address field layout, broadcast ID and FSM/opcode-class enums.
package cgra_cfg_pkg;

    localparam int CFG_TID_LSB = 0;
    localparam int CFG_IDX_LSB = 16;
    localparam int CFG_IDX_W   = 8;
    localparam int CFG_OP_LSB  = 24;
    localparam int CFG_OP_W    = 8;

    localparam logic [CFG_OP_W-1:0] CFG_OP_WRITE     = 8'h00;
    localparam logic [CFG_OP_W-1:0] CFG_OP_READ      = 8'h01;
    localparam logic [CFG_OP_W-1:0] CFG_OP_CLEAR_ERR = 8'h02;

    localparam logic [15:0] CFG_BCAST_ID = 16'hFFFF;

    typedef enum logic {
        CFG_IDLE,
        CFG_RESP
    } cfg_state_t;

    typedef enum logic [1:0] {
        OPC_WRITE,
        OPC_READ,
        OPC_CLEAR,
        OPC_UNKNOWN
    } cfg_opc_t;

endpackage

// File: rtl/cgra_cfg_addr_decode.sv
// Combinational split of a config bus address into tile match, broadcast,
// register index range check and opcode class.
module cgra_cfg_addr_decode
    import cgra_cfg_pkg::*;
#(
    parameter int NUM_REGS  = 8,
    parameter int TILE_ID_W = 16
) (
    input  logic [31:0]          config_addr_in,
    input  logic [TILE_ID_W-1:0] tile_id,
    output logic                 hit,
    output logic                 bcast,
    output logic                 idx_ok,
    output logic [CFG_IDX_W-1:0] idx,
    output cfg_opc_t             opc
);

    logic [TILE_ID_W-1:0] tid;
    logic [CFG_OP_W-1:0]  op;

    assign tid    = config_addr_in[CFG_TID_LSB +: TILE_ID_W];
    assign idx    = config_addr_in[CFG_IDX_LSB +: CFG_IDX_W];
    assign op     = config_addr_in[CFG_OP_LSB +: CFG_OP_W];

    assign bcast  = (tid == CFG_BCAST_ID[TILE_ID_W-1:0]);
    assign hit    = (tid == tile_id) || bcast;
    assign idx_ok = (int'(idx) < NUM_REGS);

    always_comb begin
        case (op)
            CFG_OP_WRITE:     opc = OPC_WRITE;
            CFG_OP_READ:      opc = OPC_READ;
            CFG_OP_CLEAR_ERR: opc = OPC_CLEAR;
            default:          opc = OPC_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/cgra_tile_config_responder.sv
// Tile-side configuration bus endpoint: register writes, sticky error, readback.
// Define CFG_READBACK_EN to build the READ path, RESP state and read channel.
module cgra_tile_config_responder
    import cgra_cfg_pkg::*;
#(
    parameter int NUM_REGS  = 8,
    parameter int DATA_W    = 32,
    parameter int TILE_ID_W = 16
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic [TILE_ID_W-1:0]         tile_id,
    input  logic [31:0]                  config_addr_in,
    input  logic [DATA_W-1:0]            config_data_in,
    input  logic                         config_valid_in,
    output logic                         config_ready_out,
    output logic [DATA_W-1:0]            read_data_out,
    output logic                         read_valid_out,
    input  logic                         read_ready_in,
    output logic [NUM_REGS*DATA_W-1:0]   cfg_regs_out,
    output logic                         cfg_err_out
);

    logic                 hit, bcast, idx_ok;
    logic [CFG_IDX_W-1:0] idx;
    cfg_opc_t             opc;

    cgra_cfg_addr_decode #(
        .NUM_REGS  (NUM_REGS),
        .TILE_ID_W (TILE_ID_W)
    ) u_decode (
        .config_addr_in (config_addr_in),
        .tile_id        (tile_id),
        .hit            (hit),
        .bcast          (bcast),
        .idx_ok         (idx_ok),
        .idx            (idx),
        .opc            (opc)
    );

    cfg_state_t        state_q, state_d;
    logic              active_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              xfer, wr_en, err_set, err_clr;
`ifdef CFG_READBACK_EN
    logic              rd_start;
`endif

    assign xfer = config_valid_in && config_ready_out;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d          = state_q;
        config_ready_out = active_q && (state_q == CFG_IDLE);
        wr_en            = 1'b0;
        err_set          = 1'b0;
        err_clr          = 1'b0;
`ifdef CFG_READBACK_EN
        rd_start         = 1'b0;
`endif
        case (state_q)
            CFG_IDLE: begin
                if (xfer && hit) begin
                    case (opc)
                        OPC_WRITE: begin
                            if (idx_ok) wr_en   = 1'b1;
                            else        err_set = 1'b1;
                        end
                        OPC_READ: begin
`ifdef CFG_READBACK_EN
                            // Broadcast reads are swallowed: no response, no error.
                            if (!bcast) begin
                                if (idx_ok) begin
                                    rd_start = 1'b1;
                                    state_d  = CFG_RESP;
                                end else begin
                                    err_set = 1'b1;
                                end
                            end
`endif
                        end
                        OPC_CLEAR: err_clr = 1'b1;
                        default:   err_set = 1'b1;
                    endcase
                end
            end
            CFG_RESP: begin
                if (read_ready_in) state_d = CFG_IDLE;
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q     <= CFG_IDLE;
            active_q    <= 1'b0;
            cfg_err_out <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
            if (err_clr)      cfg_err_out <= 1'b0;
            else if (err_set) cfg_err_out <= 1'b1;
        end
    end

    // NOTE: the config registers are reset because they drive routing/op select directly.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(idx) == i) regs_q[i] <= config_data_in;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_regs_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

`ifdef CFG_READBACK_EN
    logic [DATA_W-1:0] rd_sel, rdata_q;

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx) == i) rd_sel = regs_q[i];
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)        rdata_q <= '0;
        else if (rd_start) rdata_q <= rd_sel;
    end

    assign read_data_out  = rdata_q;
    assign read_valid_out = (state_q == CFG_RESP);
`else
    assign read_data_out  = '0;
    assign read_valid_out = 1'b0;
`endif

endmodule
